mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter sharing the single 256-bit off-chip `Data_Memory` port between the data cache (requester 0) and the instruction-side cache (requester 1). It sits between the cache controllers and `Data_Memory`, and owns the memory `enable`/`ack` handshake. It latches the winning request, holds it stable until the memory acknowledges, returns the line to the winner, and alternates priority round-robin. A watchdog flags transactions the memory never acknowledges.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width
- `LINE_WIDTH`, 256, cache-line width
- `TIMEOUT`, 64, cycles in BUSY without ack before `err_o` sets (range 1..255)

Ports:
- `clk_i` in 1: clock, all logic on rising edge
- `rst_i` in 1: synchronous, active-high reset
- `req0_enable_i`, `req1_enable_i` in 1: request pending; held high until the matching ack is sampled
- `req0_write_i`, `req1_write_i` in 1: 1 = line write, 0 = line read
- `req0_addr_i`, `req1_addr_i` in `ADDR_WIDTH`: line address
- `req0_data_i`, `req1_data_i` in `LINE_WIDTH`: write line
- `req0_ack_o`, `req1_ack_o` out 1: one-cycle completion pulse
- `req0_data_o`, `req1_data_o` out `LINE_WIDTH`: read line, valid while the matching ack is high
- `mem_enable_o` out 1, `mem_write_o` out 1, `mem_addr_o` out `ADDR_WIDTH`, `mem_data_o` out `LINE_WIDTH`: memory-side request
- `mem_ack_i` in 1, `mem_data_i` in `LINE_WIDTH`: memory completion and read data
- `grant_o` out 2: one-hot owner, `00` when idle
- `busy_o` out 1: state ≠ IDLE
- `err_o` out 1: sticky error, cleared only by reset

## Operation
- States: IDLE, BUSY, RELEASE.
- **IDLE**
  - If no `reqN_enable_i` is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the requester not served last.
  - `last` resets to 1, so requester 0 wins the first tie.
  - On grant, latch `write`/`addr`/`data` into internal registers, set `grant_o`, and go to BUSY.
- **BUSY**
  - `mem_enable_o` = 1.
  - `mem_write_o`, `mem_addr_o`, `mem_data_o` are driven from the latched registers, so they stay stable even if the requester's inputs change.
  - On `mem_ack_i`: capture `mem_data_i`, set `last` to the owner, and go to RELEASE.
  - The watchdog counter increments each BUSY cycle. When it reaches `TIMEOUT`, set `err_o` and stay in BUSY; the transaction is not aborted.
- **RELEASE**
  - `mem_enable_o` = 0.
  - The owner's `reqN_ack_o` = 1, and `reqN_data_o` = the captured line (also driven on write completions).
  - Next state is always IDLE; `grant_o` clears on entering IDLE.
- `mem_ack_i` high in IDLE or RELEASE is ignored for data and sets `err_o`.
- Requester enable during RELEASE is never sampled. The requester drops enable at the same edge at which it sees ack, so no request is double-served.
- The non-owner may assert or deassert its request freely and is never acked spuriously.
- `reqN_data_o` holds its last value outside ack cycles; consumers use it only while ack is high.

## Timing
- **Reset values:**
  - all `*_ack_o`, `mem_enable_o`, `mem_write_o`, `busy_o`, `err_o` = 0
  - `grant_o` = `00`
  - `mem_addr_o`, `mem_data_o`, `reqN_data_o` = 0
  - state = IDLE, `last` = 1, watchdog = 0
- Request sampled high at edge k (in IDLE) → `mem_enable_o` high from edge k.
- `mem_ack_i` sampled at edge m → `reqN_ack_o` high for cycle m..m+1 → IDLE at m+1.
- Memory sees `enable` low for at least one cycle between transactions.
- Minimum spacing is 3 cycles from one grant to the next; back-to-back alternating requests are each served once per round.
- Reset asserted mid-BUSY: the transaction is abandoned and no ack is issued. The memory shares `rst_i` and resets too.
- Watchdog width is 8 bits and saturates at `TIMEOUT`.
- All outputs are registered; there is no combinational path from the `req*` inputs to `mem_*` outputs.

## Test plan
1. **Reset:** hold `rst_i` 3 cycles → all outputs 0, `grant_o` = `00`.
2. **Single read:** requester 0 reads 0x20 with the memory model at latency 10 → `mem_enable_o` high 10 cycles. `req0_ack_o` pulses one cycle with the model's line for 0x20; `req1_ack_o` never pulses.
3. **Simultaneous requests:** requester 0 writes 0x400, requester 1 reads 0x0 (n = 5 preloaded) → requester 0 is served first, then requester 1. `req1_data_o` = `256'h5`, and memory line 32 holds the written data.
4. **Round-robin fairness:** both requests held continuously for 6 transactions → grants alternate 0,1,0,1,0,1 with exactly one idle cycle between transactions.
5. **Input stability:** requester 0 changes `req0_addr_i` mid-BUSY → `mem_addr_o` stays at the latched value until RELEASE.
6. **Watchdog and spurious ack:** memory never acks with `TIMEOUT` = 8 → `err_o` rises after 8 BUSY cycles and stays high. Separately, `mem_ack_i` pulsed in IDLE → `err_o` = 1 with no requester ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the shared 256-bit Data_Memory port
// (requester 0 = data cache, requester 1 = instruction-side cache).
// Latency: grant registered at the edge a request is sampled in IDLE; ack one
// cycle after mem_ack_i is sampled; minimum grant-to-grant spacing 3 cycles.
// Backpressure: requesters hold enable until their ack; the memory stalls the
// owner by withholding mem_ack_i, and a saturating watchdog flags err_o.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   reqN_enable/write/addr/data_i     request from requester N (held until ack)
//   reqN_ack_o, reqN_data_o           one-cycle completion pulse and line
//   mem_enable/write/addr/data_o      memory-side request (latched copy)
//   mem_ack_i, mem_data_i             memory completion and read line
//   grant_o                           one-hot owner, 00 when idle
//   busy_o, err_o                     not-idle flag, sticky error flag
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_enable_i,
  input  logic                  req0_write_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [LINE_WIDTH-1:0] req0_data_i,
  output logic                  req0_ack_o,
  output logic [LINE_WIDTH-1:0] req0_data_o,
  input  logic                  req1_enable_i,
  input  logic                  req1_write_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [LINE_WIDTH-1:0] req1_data_i,
  output logic                  req1_ack_o,
  output logic [LINE_WIDTH-1:0] req1_data_o,
  output logic                  mem_enable_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [LINE_WIDTH-1:0] mem_data_o,
  input  logic                  mem_ack_i,
  input  logic [LINE_WIDTH-1:0] mem_data_i,
  output logic [1:0]            grant_o,
  output logic                  busy_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t                state, state_nxt;
  logic                  last, last_nxt;     // requester served most recently
  logic                  owner, owner_nxt;   // requester holding the port
  logic [7:0]            wd, wd_nxt;         // BUSY cycles without ack
  logic                  pick;
  logic                  err_nxt;
  logic [1:0]            grant_nxt;
  logic                  enable_nxt;
  logic                  write_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [LINE_WIDTH-1:0] wdata_nxt;
  logic                  ack0_nxt, ack1_nxt;
  logic [LINE_WIDTH-1:0] rdata0_nxt, rdata1_nxt;
  logic                  busy_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      last         <= 1'b1;
      owner        <= 1'b0;
      wd           <= 8'd0;
      err_o        <= 1'b0;
      grant_o      <= 2'b00;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      req0_ack_o   <= 1'b0;
      req1_ack_o   <= 1'b0;
      req0_data_o  <= '0;
      req1_data_o  <= '0;
      busy_o       <= 1'b0;
    end else begin
      state        <= state_nxt;
      last         <= last_nxt;
      owner        <= owner_nxt;
      wd           <= wd_nxt;
      err_o        <= err_nxt;
      grant_o      <= grant_nxt;
      mem_enable_o <= enable_nxt;
      mem_write_o  <= write_nxt;
      mem_addr_o   <= addr_nxt;
      mem_data_o   <= wdata_nxt;
      req0_ack_o   <= ack0_nxt;
      req1_ack_o   <= ack1_nxt;
      req0_data_o  <= rdata0_nxt;
      req1_data_o  <= rdata1_nxt;
      busy_o       <= busy_nxt;
    end
  end

  // Every output is computed one cycle ahead and registered, so nothing on the
  // memory side depends combinationally on the requester inputs.
  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    owner_nxt  = owner;
    wd_nxt     = wd;
    err_nxt    = err_o;
    grant_nxt  = grant_o;
    enable_nxt = mem_enable_o;
    write_nxt  = mem_write_o;
    addr_nxt   = mem_addr_o;
    wdata_nxt  = mem_data_o;
    ack0_nxt   = 1'b0;
    ack1_nxt   = 1'b0;
    rdata0_nxt = req0_data_o;
    rdata1_nxt = req1_data_o;
    pick       = 1'b0;

    case (state)
      IDLE: begin
        if (mem_ack_i) err_nxt = 1'b1;
        if (req0_enable_i || req1_enable_i) begin
          // On a tie the requester not served last wins; otherwise the sole one.
          pick       = (req0_enable_i && req1_enable_i) ? ~last : req1_enable_i;
          owner_nxt  = pick;
          grant_nxt  = pick ? 2'b10 : 2'b01;
          enable_nxt = 1'b1;
          write_nxt  = pick ? req1_write_i : req0_write_i;
          addr_nxt   = pick ? req1_addr_i  : req0_addr_i;
          wdata_nxt  = pick ? req1_data_i  : req0_data_i;
          wd_nxt     = 8'd0;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          enable_nxt = 1'b0;
          last_nxt   = owner;
          state_nxt  = RELEASE;
          // The returned line is loaded straight into the owner's output so it
          // is valid in the same cycle as the ack pulse, writes included.
          if (owner) begin
            ack1_nxt   = 1'b1;
            rdata1_nxt = mem_data_i;
          end else begin
            ack0_nxt   = 1'b1;
            rdata0_nxt = mem_data_i;
          end
        end else if (wd < TIMEOUT_CNT) begin
          // Saturating count; the transaction keeps waiting after the flag.
          wd_nxt = wd + 8'd1;
          if (wd + 8'd1 == TIMEOUT_CNT) err_nxt = 1'b1;
        end
      end
      RELEASE: begin
        if (mem_ack_i) err_nxt = 1'b1;
        grant_nxt = 2'b00;
        state_nxt = IDLE;
      end
      default: begin
        grant_nxt  = 2'b00;
        enable_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed reset/watchdog/spurious-ack
// steps plus randomized request traffic against a transaction-level model.
// A behavioural memory with programmable latency answers on the memory port.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req0_enable_i, req1_enable_i, req0_write_i, req1_write_i;
  logic [AW-1:0] req0_addr_i, req1_addr_i;
  logic [LW-1:0] req0_data_i, req1_data_i;
  logic          req0_ack_o, req1_ack_o;
  logic [LW-1:0] req0_data_o, req1_data_o;
  logic          mem_enable_o, mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_data_o;
  logic          mem_ack_i;
  logic [LW-1:0] mem_data_i;
  logic [1:0]    grant_o;
  logic          busy_o, err_o;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_enable_i(req0_enable_i), .req0_write_i(req0_write_i),
    .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
    .req0_ack_o(req0_ack_o), .req0_data_o(req0_data_o),
    .req1_enable_i(req1_enable_i), .req1_write_i(req1_write_i),
    .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
    .req1_ack_o(req1_ack_o), .req1_data_o(req1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- behavioural memory ----------------
  logic [LW-1:0] mem [64];
  int            mem_lat = 1;
  int            mem_cnt = 0;
  bit            mem_hold = 1'b0;
  bit            mem_init = 1'b0;
  logic          mdl_ack = 1'b0;
  logic          spur_ack = 1'b0;

  assign mem_ack_i = mdl_ack | spur_ack;

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Acks once enable has been seen for mem_lat cycles; returns the old line
  // (read-before-write) and stores write data at the same moment.
  always @(negedge clk_i) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] = LW'(i + 5);
      mem_init = 1'b1;
    end
    if (rst_i || !mem_enable_o) begin
      mem_cnt    = 0;
      mdl_ack    = 1'b0;
      mem_data_i = rnd_line();
    end else begin
      mem_cnt++;
      if (!mem_hold && mem_cnt == mem_lat) begin
        mdl_ack    = 1'b1;
        mem_data_i = mem[mem_addr_o[10:5]];
        if (mem_write_o) mem[mem_addr_o[10:5]] = mem_data_o;
      end else begin
        mdl_ack    = 1'b0;
        mem_data_i = rnd_line();
      end
    end
  end

  // ---------------- reference model state ----------------
  int            total = 0;
  int            fails = 0;
  bit            pend [2];
  bit            f_w [2];
  logic [AW-1:0] f_a [2];
  logic [LW-1:0] f_d [2];
  int            last_m;
  bit            err_exp;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] want);
    total++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic drive();
    req0_enable_i = pend[0]; req0_write_i = f_w[0];
    req0_addr_i   = f_a[0];  req0_data_i  = f_d[0];
    req1_enable_i = pend[1]; req1_write_i = f_w[1];
    req1_addr_i   = f_a[1];  req1_data_i  = f_d[1];
  endtask

  task automatic post(input int r, input bit w, input logic [AW-1:0] a, input logic [LW-1:0] d);
    pend[r] = 1'b1; f_w[r] = w; f_a[r] = a; f_d[r] = d;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return AW'($urandom_range(0, 63)) << 5;
  endfunction

  task automatic do_reset();
    rst_i = 1'b1; mem_hold = 1'b0; spur_ack = 1'b0;
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; f_w[r] = 1'b0; f_a[r] = '0; f_d[r] = '0;
    end
    drive();
    repeat (3) tick();
    rst_i = 1'b0; last_m = 1; err_exp = 1'b0;
  endtask

  // One complete transaction for whichever requester the model says wins.
  task automatic serve(input int lat, output int win);
    int            waited;
    int            en_cyc;
    bit            got;
    bit            stable;
    bit            xw;
    logic [AW-1:0] xa;
    logic [LW-1:0] xd, xline;
    mem_lat = lat;
    drive();
    waited = 0;
    do begin tick(); waited++; end while (grant_o == 2'b00 && waited < 8);
    chk("grant_latency", waited, 1);
    win = (pend[0] && pend[1]) ? (last_m == 1 ? 0 : 1) : (pend[0] ? 0 : 1);
    chk("grant", grant_o, 2'b01 << win);
    xw = f_w[win]; xa = f_a[win]; xd = f_d[win]; xline = mem[xa[10:5]];
    chk("busy_enable", {busy_o, mem_enable_o}, 2'b11);
    chk("mem_write", mem_write_o, xw);
    chk("mem_addr", mem_addr_o, xa);
    chk("mem_data", mem_data_o, xd);
    // Owner changes its request fields mid-transaction; latched copy must hold.
    if (win == 0) begin
      req0_addr_i = rnd_addr(); req0_data_i = rnd_line(); req0_write_i = ~xw;
    end else begin
      req1_addr_i = rnd_addr(); req1_data_i = rnd_line(); req1_write_i = ~xw;
    end
    en_cyc = 1; got = 1'b0; stable = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (req0_ack_o || req1_ack_o) got = 1'b1;
      else begin
        if (mem_enable_o) en_cyc++;
        if (mem_addr_o !== xa || mem_data_o !== xd || mem_write_o !== xw) stable = 1'b0;
      end
    end
    chk("ack_seen", got, 1'b1);
    chk("latched_stable", stable, 1'b1);
    chk("enable_cycles", en_cyc, lat);
    chk("ack_vec", {req1_ack_o, req0_ack_o}, 2'b01 << win);
    chk("ack_data", (win == 0) ? req0_data_o : req1_data_o, xline);
    chk("release_enable_low", mem_enable_o, 1'b0);
    if (lat > TO) err_exp = 1'b1;
    chk("err", err_o, err_exp);
    if (xw) chk("mem_written", mem[xa[10:5]], xd);
    pend[win] = 1'b0;
    drive();
    last_m = win;
    tick();
    chk("idle_state", {grant_o, req1_ack_o, req0_ack_o, mem_enable_o, busy_o}, '0);
  endtask

  initial begin
    int            w;
    logic [LW-1:0] wline;

    // 1. reset
    do_reset();
    rst_i = 1'b1; tick();
    chk("rst_ctl", {req0_ack_o, req1_ack_o, mem_enable_o, mem_write_o, busy_o, err_o, grant_o}, '0);
    chk("rst_mem_addr", mem_addr_o, '0);
    chk("rst_mem_data", mem_data_o, '0);
    chk("rst_rd_data", {req0_data_o[127:0], req1_data_o[127:0]}, '0);
    rst_i = 1'b0; tick();
    chk("post_rst_idle", {grant_o, busy_o, mem_enable_o, err_o}, '0);

    // 2. single read, latency 10 (exceeds watchdog limit of 8)
    do_reset();
    post(0, 1'b0, 32'h20, rnd_line());
    serve(10, w);
    chk("t2_winner", w, 0);
    chk("t2_line", req0_data_o, mem[1]);

    // 3. simultaneous write/read, requester 0 wins the first tie
    do_reset();
    wline = rnd_line();
    post(0, 1'b1, 32'h400, wline);
    post(1, 1'b0, 32'h0, rnd_line());
    serve(3, w);
    chk("t3_first", w, 0);
    serve(3, w);
    chk("t3_second", w, 1);
    chk("t3_rd1", req1_data_o, 256'h5);
    chk("t3_line32", mem[32], wline);

    // 4. both requesters held continuously: strict alternation
    post(0, $urandom_range(0, 1), rnd_addr(), rnd_line());
    post(1, $urandom_range(0, 1), rnd_addr(), rnd_line());
    for (int i = 0; i < 6; i++) begin
      serve($urandom_range(1, 6), w);
      chk("t4_alternate", w, i % 2);
      post(w, $urandom_range(0, 1), rnd_addr(), rnd_line());
    end

    // 6a. memory never acks: watchdog
    do_reset();
    mem_hold = 1'b1;
    post(0, 1'b0, 32'h40, rnd_line());
    drive();
    tick();
    chk("wd_grant", grant_o, 2'b01);
    repeat (7) tick();
    chk("wd_err_early", err_o, 1'b0);
    tick();
    chk("wd_err_set", err_o, 1'b1);
    repeat (20) tick();
    chk("wd_hold", {err_o, busy_o, mem_enable_o, req0_ack_o, req1_ack_o}, 5'b11100);

    // reset mid-BUSY abandons the transaction without an ack
    do_reset();
    tick();
    chk("abandon", {req0_ack_o, req1_ack_o, busy_o, err_o, grant_o}, '0);

    // 6b. spurious ack in IDLE
    spur_ack = 1'b1;
    tick();
    spur_ack = 1'b0;
    chk("spur_err", {err_o, req0_ack_o, req1_ack_o, busy_o}, 4'b1000);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 24; i++) begin
      if (!pend[0] && !pend[1]) begin
        int r;
        r = $urandom_range(1, 3);
        if (r[0]) post(0, $urandom_range(0, 1), rnd_addr(), rnd_line());
        if (r[1]) post(1, $urandom_range(0, 1), rnd_addr(), rnd_line());
      end else if ($urandom_range(0, 1) == 1) begin
        if (!pend[0]) post(0, $urandom_range(0, 1), rnd_addr(), rnd_line());
        else          post(1, $urandom_range(0, 1), rnd_addr(), rnd_line());
      end
      serve($urandom_range(1, 6), w);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
